// File: rtl/bit_balance_pkg.sv
// bit_balance_pkg
// Shared definitions for the bit_balance_stream block:
//   - bb_state_t     : word-sequencer FSM states (IDLE, COUNT, HOLD)
//   - count_width()  : width of a count able to hold 0..w
//   - sat_add()      : 32-bit saturating add returning {overflow, result}
package bit_balance_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } bb_state_t;

    // Number of bits needed to represent any value in 0..w.
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Saturating add of two unsigned operands against an upper limit.
    // Bit 32 of the result flags that the true sum exceeded the limit;
    // bits 31:0 carry the (possibly clamped) sum.
    function automatic logic [32:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] limit
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, limit}) begin
            return {1'b1, limit};
        end else begin
            return {1'b0, sum[31:0]};
        end
    endfunction

endpackage

// File: rtl/bit_balance_stream_popcount.sv
// popcount_slice
// Combinational ones counter for one slice of the input word.
// Ports:
//   slice : SLICE_W-bit slice to count
//   count : number of ones in slice, $clog2(SLICE_W+1) bits
module popcount_slice
    import bit_balance_pkg::*;
#(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0]                slice,
    output logic [count_width(SLICE_W)-1:0]   count
);

    localparam int PW = count_width(SLICE_W);

    // Sum the individual bits of the slice.
    always_comb begin
        count = {PW{1'b0}};
        for (int i = 0; i < SLICE_W; i++) begin
            count = count + PW'(slice[i]);
        end
    end

endmodule

// File: rtl/bit_balance_stream.sv
// bit_balance_stream
// Streaming ones counter. Accepts a DATA_W-bit word over valid/ready, counts
// its ones SLICE_W bits per cycle (LSB slice first), then presents the ones
// count and the signed ones-minus-zeros disparity until the consumer takes it.
// Optional frame accumulator (build with BITBAL_FRAME_EN defined) sums the
// ones of every word of a frame closed by in_last, saturating at 2^ACC_W-1.
// ACC_W is limited to 32 bits by the shared saturating adder.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : input handshake (in_ready is the only unregistered output)
//   in_data         : word to count
//   in_last         : word closes a frame (frame build only)
//   out_valid/ready : result handshake
//   out_count       : ones in the word
//   out_disparity   : 2*out_count - DATA_W, two's complement
//   out_frame_ones  : frame total including the current word (frame build)
//   out_frame_end   : current result closes a frame (frame build)
//   out_sat         : frame total saturated (frame build)
module bit_balance_stream
    import bit_balance_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 8,
    parameter int ACC_W   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [count_width(DATA_W)-1:0]   out_count,
    output logic [count_width(DATA_W):0]     out_disparity,
    output logic [ACC_W-1:0]                 out_frame_ones,
    output logic                             out_frame_end,
    output logic                             out_sat
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int CW     = count_width(DATA_W);
    localparam int PW     = count_width(SLICE_W);
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);
    localparam logic [CW:0]   DATA_W_C = (CW + 1)'(DATA_W);

    bb_state_t          state_r;
    bb_state_t          state_s;
    logic [DATA_W-1:0]  word_r;
    logic [CW-1:0]      cnt_r;
    logic [IW-1:0]      idx_r;
    logic [PW-1:0]      slice_pop_s;
    logic [CW-1:0]      cnt_sum_s;
    logic               accept_s;
    logic               count_done_s;
    logic               release_s;

    logic               out_valid_r;
    logic [CW-1:0]      out_count_r;
    logic [CW:0]        out_disp_r;

    // The slice currently at the bottom of the shifting word.
    popcount_slice #(
        .SLICE_W (SLICE_W)
    ) u_popcount (
        .slice (word_r[SLICE_W-1:0]),
        .count (slice_pop_s)
    );

    assign cnt_sum_s    = cnt_r + CW'(slice_pop_s);
    assign accept_s     = in_valid && (state_r == ST_IDLE);
    assign count_done_s = (state_r == ST_COUNT) && (idx_r == LAST_IDX);
    assign release_s    = (state_r == ST_HOLD) && out_ready;

    // Ready is held low during reset so nothing is accepted while it is applied.
    assign in_ready = (state_r == ST_IDLE) && !rst;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s = ST_COUNT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (idx_r == LAST_IDX) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_COUNT;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Word latch, slice shifter and running per-word count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_r <= {DATA_W{1'b0}};
            cnt_r  <= {CW{1'b0}};
            idx_r  <= {IW{1'b0}};
        end else if (accept_s) begin
            word_r <= in_data;
            cnt_r  <= {CW{1'b0}};
            idx_r  <= {IW{1'b0}};
        end else if (state_r == ST_COUNT) begin
            word_r <= word_r >> SLICE_W;
            cnt_r  <= cnt_sum_s;
            idx_r  <= idx_r + IW'(1);
        end
    end

    // Per-word result registers; loaded as the last slice is counted and
    // held until the consumer takes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_count_r <= {CW{1'b0}};
            out_disp_r  <= {(CW + 1){1'b0}};
        end else if (count_done_s) begin
            out_valid_r <= 1'b1;
            out_count_r <= cnt_sum_s;
            out_disp_r  <= {cnt_sum_s, 1'b0} - DATA_W_C;
        end else if (release_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid     = out_valid_r;
    assign out_count     = out_count_r;
    assign out_disparity = out_disp_r;

`ifdef BITBAL_FRAME_EN

    localparam logic [31:0] ACC_MAX = 32'({ACC_W{1'b1}});

    logic [ACC_W-1:0]   acc_r;
    logic               sat_r;
    logic               last_r;
    logic               frame_end_r;
    logic [31:0]        acc_next_s;
    logic               acc_ovf_s;
    logic [31:0]        acc_next_unused_s;

    assign {acc_ovf_s, acc_next_s} = sat_add(32'(acc_r), 32'(cnt_sum_s), ACC_MAX);
    assign acc_next_unused_s       = acc_next_s;

    // Frame accumulator: add each finished word, clear once the closing
    // word of the frame has been handed over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r       <= {ACC_W{1'b0}};
            sat_r       <= 1'b0;
            last_r      <= 1'b0;
            frame_end_r <= 1'b0;
        end else begin
            if (accept_s) begin
                last_r <= in_last;
            end
            if (count_done_s) begin
                acc_r       <= acc_next_s[ACC_W-1:0];
                frame_end_r <= last_r;
                if (acc_ovf_s) begin
                    sat_r <= 1'b1;
                end
            end else if (release_s) begin
                frame_end_r <= 1'b0;
                if (frame_end_r) begin
                    acc_r <= {ACC_W{1'b0}};
                    sat_r <= 1'b0;
                end
            end
        end
    end

    assign out_frame_ones = acc_r;
    assign out_frame_end  = frame_end_r;
    assign out_sat        = sat_r;

`else

    logic in_last_unused_s;

    assign in_last_unused_s = in_last;
    assign out_frame_ones   = {ACC_W{1'b0}};
    assign out_frame_end    = 1'b0;
    assign out_sat          = 1'b0;

`endif

endmodule
